// File: rtl/vga_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// vga_transmitter_pkg
// Shared VGA timing definitions used by the transmit path and by receive-side
// converters: 640x480@60 timing constants, sync polarities, the raw timing
// record carried down the read-latency delay line, and a total-period helper.
// -----------------------------------------------------------------------------
package vga_transmitter_pkg;

    // 640x480 horizontal timing, in pixels
    localparam int VGA_HACT = 640;
    localparam int VGA_HFP  = 16;
    localparam int VGA_HSW  = 96;
    localparam int VGA_HBP  = 48;

    // 640x480 vertical timing, in lines
    localparam int VGA_VACT = 480;
    localparam int VGA_VFP  = 10;
    localparam int VGA_VSH  = 2;
    localparam int VGA_VBP  = 33;

    // Sync active levels (0 = active-low)
    localparam int VGA_HSYNC_POL = 0;
    localparam int VGA_VSYNC_POL = 0;

    // Raw timing flags for one pixel position; syncs are "active" flags,
    // polarity is applied only at the output register.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } vga_raw_t;

    // Full period of a line or frame from its four segments.
    function automatic int vga_total(input int act, input int fp, input int sw, input int bp);
        return act + fp + sw + bp;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// -----------------------------------------------------------------------------
// vga_timing_counter
// Horizontal/vertical position counters plus the raw timing decode for one
// VGA raster. Segment order per line and per frame: active, front porch,
// sync, back porch. Reusable by receive-side logic.
//
// Ports
//   clk_i          pixel clock
//   rst_ni         asynchronous active-low reset
//   enable_i       run/idle; low clears the position to (0,0) at the next edge
//   h_o, v_o       current horizontal / vertical position
//   de_o           position is inside the active area (and running)
//   hsync_act_o    horizontal sync region (active flag, polarity-free)
//   vsync_act_o    vertical sync region (active flag, polarity-free)
//   frame_start_o  position (0,0) while running
// -----------------------------------------------------------------------------
module vga_timing_counter
    import vga_transmitter_pkg::*;
#(
    parameter  int P_HACT = VGA_HACT,
    parameter  int P_HFP  = VGA_HFP,
    parameter  int P_HSW  = VGA_HSW,
    parameter  int P_HBP  = VGA_HBP,
    parameter  int P_VACT = VGA_VACT,
    parameter  int P_VFP  = VGA_VFP,
    parameter  int P_VSH  = VGA_VSH,
    parameter  int P_VBP  = VGA_VBP,
    localparam int HT     = vga_total(P_HACT, P_HFP, P_HSW, P_HBP),
    localparam int VT     = vga_total(P_VACT, P_VFP, P_VSH, P_VBP),
    localparam int HW     = $clog2(HT),
    localparam int VW     = $clog2(VT)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enable_i,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output logic          de_o,
    output logic          hsync_act_o,
    output logic          vsync_act_o,
    output logic          frame_start_o
);

    // Thresholds carry one extra bit so a segment end equal to 2**HW
    // (e.g. zero back porch) is not truncated.
    localparam logic [HW:0] H_LAST   = (HW+1)'(HT - 1);
    localparam logic [HW:0] H_ACT    = (HW+1)'(P_HACT);
    localparam logic [HW:0] H_SYNC_S = (HW+1)'(P_HACT + P_HFP);
    localparam logic [HW:0] H_SYNC_E = (HW+1)'(P_HACT + P_HFP + P_HSW);
    localparam logic [VW:0] V_LAST   = (VW+1)'(VT - 1);
    localparam logic [VW:0] V_ACT    = (VW+1)'(P_VACT);
    localparam logic [VW:0] V_SYNC_S = (VW+1)'(P_VACT + P_VFP);
    localparam logic [VW:0] V_SYNC_E = (VW+1)'(P_VACT + P_VFP + P_VSH);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          run_q, run_d;
    logic [HW:0]   h_x;
    logic [VW:0]   v_x;

    // run_q delays the first advance by one edge, so after enable (or reset
    // release) the position (0,0) is presented for a full cycle.
    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        run_d = enable_i;
        if (!enable_i) begin
            h_d = '0;
            v_d = '0;
        end else if (run_q) begin
            if ({1'b0, h_q} == H_LAST) begin
                h_d = '0;
                v_d = ({1'b0, v_q} == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q   <= '0;
            v_q   <= '0;
            run_q <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            run_q <= run_d;
        end
    end

    assign h_x = {1'b0, h_q};
    assign v_x = {1'b0, v_q};

    assign h_o           = h_q;
    assign v_o           = v_q;
    assign de_o          = run_q && (h_x < H_ACT) && (v_x < V_ACT);
    assign hsync_act_o   = run_q && (h_x >= H_SYNC_S) && (h_x < H_SYNC_E);
    assign vsync_act_o   = run_q && (v_x >= V_SYNC_S) && (v_x < V_SYNC_E);
    assign frame_start_o = run_q && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_transmitter.sv
// -----------------------------------------------------------------------------
// vga_transmitter
// Scans a grayscale frame buffer in raster order and emits VGA video: read
// strobes/addresses go out combinationally from the position counters, the
// raw timing is delayed by the memory read latency, and the final register
// aligns sync/DE/frame-start with the replicated {g,g,g} pixel.
//
// Ports
//   I_CLK           pixel clock
//   I_RESET         asynchronous active-low reset
//   I_ENABLE        run/idle; low flushes everything and restarts at (0,0)
//   I_PIXEL         grayscale read data, valid P_READ_LATENCY cycles after read
//   O_READ_ENABLE   read strobe for one active pixel
//   O_READ_COLUMN   column being read (0 when not reading)
//   O_READ_ROW      row being read (0 when not reading)
//   O_PIXEL         RGB pixel, zero outside the active area
//   O_HSYNC/O_VSYNC sync outputs at the configured polarity
//   O_DATA_ENABLE   active-video qualifier
//   O_FRAME_START   one-cycle pulse on the first active pixel of a frame
// -----------------------------------------------------------------------------
module vga_transmitter
    import vga_transmitter_pkg::*;
#(
    parameter int P_PIXEL_DEPTH  = 24,
    parameter int P_HACT         = VGA_HACT,
    parameter int P_HFP          = VGA_HFP,
    parameter int P_HSW          = VGA_HSW,
    parameter int P_HBP          = VGA_HBP,
    parameter int P_VACT         = VGA_VACT,
    parameter int P_VFP          = VGA_VFP,
    parameter int P_VSH          = VGA_VSH,
    parameter int P_VBP          = VGA_VBP,
    parameter int P_HSYNC_POL    = VGA_HSYNC_POL,
    parameter int P_VSYNC_POL    = VGA_VSYNC_POL,
    parameter int P_READ_LATENCY = 1
) (
    input  logic                       I_CLK,
    input  logic                       I_RESET,
    input  logic                       I_ENABLE,
    input  logic [P_PIXEL_DEPTH/3-1:0] I_PIXEL,
    output logic                       O_READ_ENABLE,
    output logic [$clog2(P_HACT)-1:0]  O_READ_COLUMN,
    output logic [$clog2(P_VACT)-1:0]  O_READ_ROW,
    output logic [P_PIXEL_DEPTH-1:0]   O_PIXEL,
    output logic                       O_HSYNC,
    output logic                       O_VSYNC,
    output logic                       O_DATA_ENABLE,
    output logic                       O_FRAME_START
);

    localparam int   HW       = $clog2(vga_total(P_HACT, P_HFP, P_HSW, P_HBP));
    localparam int   VW       = $clog2(vga_total(P_VACT, P_VFP, P_VSH, P_VBP));
    localparam int   CW       = $clog2(P_HACT);
    localparam int   RW       = $clog2(P_VACT);
    localparam logic HS_ACT   = (P_HSYNC_POL != 0);
    localparam logic HS_INACT = ~HS_ACT;
    localparam logic VS_ACT   = (P_VSYNC_POL != 0);
    localparam logic VS_INACT = ~VS_ACT;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    vga_raw_t      raw;
    vga_raw_t      dly_q [P_READ_LATENCY];
    vga_raw_t      dly_last;

    logic [P_PIXEL_DEPTH-1:0] pixel_q, pixel_d;
    logic                     hsync_q, hsync_d;
    logic                     vsync_q, vsync_d;
    logic                     de_q, de_d;
    logic                     fs_q, fs_d;

    vga_timing_counter #(
        .P_HACT (P_HACT),
        .P_HFP  (P_HFP),
        .P_HSW  (P_HSW),
        .P_HBP  (P_HBP),
        .P_VACT (P_VACT),
        .P_VFP  (P_VFP),
        .P_VSH  (P_VSH),
        .P_VBP  (P_VBP)
    ) u_timing (
        .clk_i         (I_CLK),
        .rst_ni        (I_RESET),
        .enable_i      (I_ENABLE),
        .h_o           (h),
        .v_o           (v),
        .de_o          (raw.de),
        .hsync_act_o   (raw.hs),
        .vsync_act_o   (raw.vs),
        .frame_start_o (raw.fs)
    );

    // Read side: same-cycle decode, address forced to 0 outside active area.
    assign O_READ_ENABLE = raw.de;
    assign O_READ_COLUMN = raw.de ? CW'(h) : '0;
    assign O_READ_ROW    = raw.de ? RW'(v) : '0;

    // Delay line matching the memory read latency; cleared when idle so no
    // stale partial line survives a disable.
    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            for (int i = 0; i < P_READ_LATENCY; i++) dly_q[i] <= '0;
        end else if (!I_ENABLE) begin
            for (int i = 0; i < P_READ_LATENCY; i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= raw;
            for (int i = 1; i < P_READ_LATENCY; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    assign dly_last = dly_q[P_READ_LATENCY-1];

    // Output register: I_PIXEL arrives in the same cycle as the delayed DE.
    always_comb begin
        pixel_d = '0;
        hsync_d = HS_INACT;
        vsync_d = VS_INACT;
        de_d    = 1'b0;
        fs_d    = 1'b0;
        if (I_ENABLE) begin
            pixel_d = dly_last.de ? {3{I_PIXEL}} : '0;
            hsync_d = dly_last.hs ? HS_ACT : HS_INACT;
            vsync_d = dly_last.vs ? VS_ACT : VS_INACT;
            de_d    = dly_last.de;
            fs_d    = dly_last.fs;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            pixel_q <= '0;
            hsync_q <= HS_INACT;
            vsync_q <= VS_INACT;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            pixel_q <= pixel_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
        end
    end

    assign O_PIXEL       = pixel_q;
    assign O_HSYNC       = hsync_q;
    assign O_VSYNC       = vsync_q;
    assign O_DATA_ENABLE = de_q;
    assign O_FRAME_START = fs_q;

endmodule

// File: tb/tb_vga_transmitter.sv
// -----------------------------------------------------------------------------
// tb_vga_transmitter
// Bench for vga_transmitter on a reduced raster (14 x 8 positions, 8x4 active,
// read latency 1). The frame buffer model returns row*16+col one cycle after
// each read strobe. Expected video records are queued as positions are
// scanned and popped when the output pipeline presents them.
// -----------------------------------------------------------------------------
module tb_vga_transmitter;

    localparam int HACT = 8, HFP = 2, HSW = 3, HBP = 1, HT = 14;
    localparam int VACT = 4, VFP = 1, VSH = 2, VBP = 1, VT = 8;
    localparam int LAT  = 1;
    localparam int FRAME = HT * VT;

    // {re, col, row, de, hs, vs, fs, pix}
    localparam logic [33:0] IDLE = {1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
    // {de, hs, vs, fs, pix}
    localparam logic [27:0] VID_IDLE = {1'b0, 1'b1, 1'b1, 1'b0, 24'h0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  gray = 8'h00;
    logic        re;
    logic [2:0]  col;
    logic [1:0]  row;
    logic [23:0] pix;
    logic        hs, vs, de, fs;

    int checks = 0;
    int errors = 0;
    logic [27:0] exp_q [$];

    always #5 clk = ~clk;

    vga_transmitter #(
        .P_PIXEL_DEPTH  (24),
        .P_HACT         (HACT),
        .P_HFP          (HFP),
        .P_HSW          (HSW),
        .P_HBP          (HBP),
        .P_VACT         (VACT),
        .P_VFP          (VFP),
        .P_VSH          (VSH),
        .P_VBP          (VBP),
        .P_HSYNC_POL    (0),
        .P_VSYNC_POL    (0),
        .P_READ_LATENCY (LAT)
    ) dut (
        .I_CLK         (clk),
        .I_RESET       (rst_n),
        .I_ENABLE      (en),
        .I_PIXEL       (gray),
        .O_READ_ENABLE (re),
        .O_READ_COLUMN (col),
        .O_READ_ROW    (row),
        .O_PIXEL       (pix),
        .O_HSYNC       (hs),
        .O_VSYNC       (vs),
        .O_DATA_ENABLE (de),
        .O_FRAME_START (fs)
    );

    // Frame buffer: row*16+col, one cycle latency.
    always @(posedge clk)
        gray <= re ? 8'(int'(row) * 16 + int'(col)) : 8'h00;

    function automatic logic [27:0] exp_video(input int p);
        int h, v;
        logic d, hsl, vsl, f;
        logic [7:0] g;
        h   = p % HT;
        v   = (p / HT) % VT;
        d   = (h < HACT) && (v < VACT);
        hsl = !((h >= HACT + HFP) && (h < HACT + HFP + HSW));
        vsl = !((v >= VACT + VFP) && (v < VACT + VFP + VSH));
        f   = (h == 0) && (v == 0);
        g   = 8'(v * 16 + h);
        return {d, hsl, vsl, f, d ? {g, g, g} : 24'h0};
    endfunction

    // Entered at the negedge of cycle 0 of a fresh run; returns at cycle n.
    task automatic test_frame(input int n);
        int h, v, fs_first, fs_second;
        logic en_e;
        logic [5:0] rd_e;
        logic [27:0] vid_e;
        fs_first  = -1;
        fs_second = -1;
        exp_q.delete();
        for (int c = 0; c < n; c++) begin
            h    = c % HT;
            v    = (c / HT) % VT;
            en_e = (h < HACT) && (v < VACT);
            rd_e = {en_e, en_e ? 3'(h) : 3'd0, en_e ? 2'(v) : 2'd0};
            checks++;
            if ({re, col, row} !== rd_e) begin
                errors++;
                $display("FAIL read c=%0d got %h want %h", c, {re, col, row}, rd_e);
            end
            exp_q.push_back(exp_video(c));
            vid_e = (c >= LAT + 1) ? exp_q.pop_front() : VID_IDLE;
            checks++;
            if ({de, hs, vs, fs, pix} !== vid_e) begin
                errors++;
                $display("FAIL video c=%0d got %h want %h", c, {de, hs, vs, fs, pix}, vid_e);
            end
            if (c == 2 * HT + 3 + LAT + 1) begin
                checks++;
                if (pix !== 24'h232323 || de !== 1'b1) begin
                    errors++;
                    $display("FAIL pixel_3_2 got de=%b pix=%h want de=1 pix=232323", de, pix);
                end
            end
            if (fs === 1'b1) begin
                if (fs_first < 0) fs_first = c;
                else if (fs_second < 0) fs_second = c;
            end
            @(negedge clk);
        end
        if (n > FRAME + LAT + 2) begin
            checks++;
            if (fs_first < 0 || fs_second - fs_first != FRAME) begin
                errors++;
                $display("FAIL frame_interval got %0d want %0d", fs_second - fs_first, FRAME);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({re, col, row, de, hs, vs, fs, pix} !== IDLE) begin
            errors++;
            $display("FAIL reset_state got %h want %h", {re, col, row, de, hs, vs, fs, pix}, IDLE);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_enable_drop();
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({re, col, row, de, hs, vs, fs, pix} !== IDLE) begin
                errors++;
                $display("FAIL idle i=%0d got %h want %h", i, {re, col, row, de, hs, vs, fs, pix}, IDLE);
            end
        end
        en = 1'b1;
        @(negedge clk);
        repeat (2 * HT + 5) @(negedge clk);
        checks++;
        if ({re, col, row} !== {1'b1, 3'd5, 2'd2}) begin
            errors++;
            $display("FAIL read_5_2 got %h want %h", {re, col, row}, {1'b1, 3'd5, 2'd2});
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({re, col, row, de, hs, vs, fs, pix} !== IDLE) begin
                errors++;
                $display("FAIL flush i=%0d got %h want %h", i, {re, col, row, de, hs, vs, fs, pix}, IDLE);
            end
        end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if ({re, col, row, de, fs} !== {1'b1, 3'd0, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reenable_read got %h want %h", {re, col, row, de, fs}, {1'b1, 3'd0, 2'd0, 1'b0, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({de, fs} !== 2'b00) begin
            errors++;
            $display("FAIL reenable_c1 got de/fs=%b want 00", {de, fs});
        end
        @(negedge clk);
        checks++;
        if ({de, fs, pix} !== {1'b1, 1'b1, 24'h0}) begin
            errors++;
            $display("FAIL reenable_fs got %h want %h", {de, fs, pix}, {1'b1, 1'b1, 24'h0});
        end
    endtask

    task automatic test_reset_midline();
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({re, col, row, de, hs, vs, fs, pix} !== IDLE) begin
            errors++;
            $display("FAIL async_reset got %h want %h", {re, col, row, de, hs, vs, fs, pix}, IDLE);
        end
        @(negedge clk);
        checks++;
        if ({re, col, row, de, hs, vs, fs, pix} !== IDLE) begin
            errors++;
            $display("FAIL reset_hold got %h want %h", {re, col, row, de, hs, vs, fs, pix}, IDLE);
        end
        rst_n = 1'b1;
        @(negedge clk);
        test_frame(40);
    endtask

    initial begin
        test_reset();
        test_frame(2 * FRAME + 6);
        test_enable_drop();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
